spu_dual_issue_front: RTL and testbench



---
 rtl/spu_dual_issue_front_if.sv | 22 ++
 rtl/spu_dual_issue_front.sv | 209 ++++++++++++++++++++
 tb/tb_spu_dual_issue_front.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/spu_dual_issue_front_if.sv
// Bus bundle for the SPU instruction front end: line-load inputs and the
// two issue ports (even pipe / odd pipe) plus the current pair address.
interface spu_dual_issue_front_if;
   logic [0:6]    instuction_address;
   logic [0:1023] inst_2_local;
   logic          write;
   logic [0:31]   even_inst;
   logic          even_valid;
   logic [0:31]   odd_inst;
   logic          odd_valid;
   logic [0:6]    pc;

   modport master (
      output instuction_address, inst_2_local, write,
      input  even_inst, even_valid, odd_inst, odd_valid, pc
   );

   modport slave (
      input  instuction_address, inst_2_local, write,
      output even_inst, even_valid, odd_inst, odd_valid, pc
   );
endinterface

// File: rtl/spu_dual_issue_front.sv
// Dual-issue SPU front end. A 128-word instruction store is filled one
// 1024-bit line at a time. Aligned pairs are read at pc/pc+1, classified into
// even-pipe or odd-pipe instructions, and issued together when independent or
// split over two cycles when they collide on a pipe or a register.
module spu_dual_issue_front #(
   parameter int IMEM_DEPTH = 128,
   parameter int LINE_WORDS = 32
) (
   input logic                   clk,
   input logic                   reset,
   spu_dual_issue_front_if.slave bus
);

   localparam int ADDR_W = $clog2(IMEM_DEPTH);

   // RR opcodes, bits [0:10]
   localparam logic [0:10] OP_AH      = 11'b00011001000;
   localparam logic [0:10] OP_SFH     = 11'b00001001000;
   localparam logic [0:10] OP_AVGB    = 11'b00011010011;
   localparam logic [0:10] OP_CNTB    = 11'b01010110100;
   localparam logic [0:10] OP_SHLQBI  = 11'b00111011011;
   localparam logic [0:10] OP_SHLQBY  = 11'b00111011111;
   localparam logic [0:10] OP_ROTQBI  = 11'b00111011000;
   localparam logic [0:10] OP_ROTQBY  = 11'b00111011100;
   localparam logic [0:10] OP_ROTQMBY = 11'b00111011101;
   localparam logic [0:10] OP_GB      = 11'b00110110000;
   localparam logic [0:10] OP_GBB     = 11'b00110110010;
   // RI16 opcodes, bits [0:8]
   localparam logic [0:8]  OP_ILH     = 9'b010000011;
   localparam logic [0:8]  OP_LQA     = 9'b001100001;
   localparam logic [0:8]  OP_BRNZ    = 9'b001000010;
   // RI10 opcodes, bits [0:7]
   localparam logic [0:7]  OP_XORHI   = 8'b01000101;
   localparam logic [0:7]  OP_ANDHI   = 8'b00010101;
   localparam logic [0:7]  OP_CEQBI   = 8'b01111110;
   localparam logic [0:7]  OP_CGTI    = 8'b01001100;
   localparam logic [0:7]  OP_XORI    = 8'b01000100;
   // RI18 opcodes, bits [0:6]
   localparam logic [0:6]  OP_ILA     = 7'b0100001;

   typedef struct packed {
      logic is_odd;
      logic reads_ra;
      logic reads_rb;
      logic has_dest;
   } dec_t;

   typedef enum logic {
      ISSUE_PAIR,
      ISSUE_SECOND
   } slot_t;

   logic [0:31]       mem [0:IMEM_DEPTH-1];
   slot_t             state;
   slot_t             state_next;
   logic [0:ADDR_W-1] pc_b;
   logic [0:31]       word_a;
   logic [0:31]       word_b;
   dec_t              dec_a;
   dec_t              dec_b;
   logic              conflict;
   logic [0:31]       even_inst_d;
   logic              even_valid_d;
   logic [0:31]       odd_inst_d;
   logic              odd_valid_d;
   logic [0:ADDR_W-1] pc_d;

   // Classify one word; the longest opcode formats are matched first so a
   // short opcode never shadows a longer one. Unknown words are even-class
   // with no sources and no destination.
   function automatic dec_t decode(input logic [0:31] w);
      dec_t d;
      d = '0;
      case (w[0:10])
         OP_AH, OP_SFH, OP_AVGB, OP_CNTB:
            d = '{is_odd: 1'b0, reads_ra: 1'b1, reads_rb: 1'b1, has_dest: 1'b1};
         OP_SHLQBI, OP_SHLQBY, OP_ROTQBI, OP_ROTQBY, OP_ROTQMBY, OP_GB, OP_GBB:
            d = '{is_odd: 1'b1, reads_ra: 1'b1, reads_rb: 1'b1, has_dest: 1'b1};
         default: begin
            case (w[0:8])
               OP_ILH:  d = '{is_odd: 1'b0, reads_ra: 1'b0, reads_rb: 1'b0, has_dest: 1'b1};
               OP_LQA:  d = '{is_odd: 1'b1, reads_ra: 1'b0, reads_rb: 1'b0, has_dest: 1'b1};
               OP_BRNZ: d = '{is_odd: 1'b1, reads_ra: 1'b0, reads_rb: 1'b0, has_dest: 1'b0};
               default: begin
                  case (w[0:7])
                     OP_XORHI, OP_ANDHI, OP_CEQBI, OP_CGTI, OP_XORI:
                        d = '{is_odd: 1'b0, reads_ra: 1'b1, reads_rb: 1'b0, has_dest: 1'b1};
                     default: begin
                        if (w[0:6] == OP_ILA) begin
                           d = '{is_odd: 1'b0, reads_ra: 1'b0, reads_rb: 1'b0, has_dest: 1'b1};
                        end
                     end
                  endcase
               end
            endcase
         end
      endcase
      return d;
   endfunction

   // Line load: the store wraps modulo its depth and is never reset.
   always_ff @(posedge clk) begin
      if (bus.write) begin
         for (int i = 0; i < LINE_WORDS; i++) begin
            mem[bus.instuction_address + ADDR_W'(i)] <= bus.inst_2_local[32*i +: 32];
         end
      end
   end

   // Read the current pair and decide whether it can go out together.
   always_comb begin
      pc_b     = {bus.pc[0:ADDR_W-2], 1'b1};
      word_a   = mem[bus.pc];
      word_b   = mem[pc_b];
      dec_a    = decode(word_a);
      dec_b    = decode(word_b);
      conflict = (dec_a.is_odd == dec_b.is_odd) ||
                 (dec_a.has_dest &&
                  ((dec_b.reads_ra && (word_b[18:24] == word_a[25:31])) ||
                   (dec_b.reads_rb && (word_b[11:17] == word_a[25:31])) ||
                   (dec_b.has_dest && (word_b[25:31] == word_a[25:31]))));
   end

   // Slot state register; reset or a line load abandons any pending half.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ISSUE_PAIR;
      end else begin
         state <= state_next;
      end
   end

   // Next slot: a conflicting pair spends one extra cycle on its second word.
   always_comb begin
      state_next = state;
      if (bus.write) begin
         state_next = ISSUE_PAIR;
      end else begin
         case (state)
            ISSUE_PAIR:   state_next = conflict ? ISSUE_SECOND : ISSUE_PAIR;
            ISSUE_SECOND: state_next = ISSUE_PAIR;
            default:      state_next = ISSUE_PAIR;
         endcase
      end
   end

   // Route words to pipes and compute the next pc; unused pipes carry zero.
   always_comb begin
      even_inst_d  = '0;
      even_valid_d = 1'b0;
      odd_inst_d   = '0;
      odd_valid_d  = 1'b0;
      pc_d         = bus.pc;
      if (bus.write) begin
         pc_d = '0;
      end else begin
         case (state)
            ISSUE_PAIR: begin
               if (dec_a.is_odd) begin
                  odd_inst_d  = word_a;
                  odd_valid_d = 1'b1;
               end else begin
                  even_inst_d  = word_a;
                  even_valid_d = 1'b1;
               end
               if (!conflict) begin
                  if (dec_a.is_odd) begin
                     even_inst_d  = word_b;
                     even_valid_d = 1'b1;
                  end else begin
                     odd_inst_d  = word_b;
                     odd_valid_d = 1'b1;
                  end
                  pc_d = bus.pc + ADDR_W'(2);
               end
            end
            ISSUE_SECOND: begin
               if (dec_b.is_odd) begin
                  odd_inst_d  = word_b;
                  odd_valid_d = 1'b1;
               end else begin
                  even_inst_d  = word_b;
                  even_valid_d = 1'b1;
               end
               pc_d = bus.pc + ADDR_W'(2);
            end
            default: pc_d = bus.pc;
         endcase
      end
   end

   // Registered issue ports and pc.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.even_inst  <= '0;
         bus.even_valid <= 1'b0;
         bus.odd_inst   <= '0;
         bus.odd_valid  <= 1'b0;
         bus.pc         <= '0;
      end else begin
         bus.even_inst  <= even_inst_d;
         bus.even_valid <= even_valid_d;
         bus.odd_inst   <= odd_inst_d;
         bus.odd_valid  <= odd_valid_d;
         bus.pc         <= pc_d;
      end
   end

endmodule

// File: tb/tb_spu_dual_issue_front.sv
// Directed bench for the dual-issue front end: reset, paired and split issue,
// wrapped line loads, pc wrap, and write/reset arriving mid-split.
module tb_spu_dual_issue_front;

   localparam logic [10:0] OP_AH      = 11'h0C8;
   localparam logic [10:0] OP_SFH     = 11'h048;
   localparam logic [10:0] OP_SHLQBI  = 11'h1DB;
   localparam logic [10:0] OP_SHLQBY  = 11'h1DF;
   localparam logic [10:0] OP_ROTQBI  = 11'h1D8;
   localparam logic [10:0] OP_ROTQBY  = 11'h1DC;
   localparam logic [10:0] OP_ROTQMBY = 11'h1DD;
   localparam logic [10:0] OP_GBB     = 11'h1B2;
   localparam logic [7:0]  OP_XORHI   = 8'h45;
   localparam logic [7:0]  OP_CEQBI   = 8'h7E;
   localparam logic [8:0]  OP_LQA     = 9'h061;
   localparam logic [6:0]  OP_ILA     = 7'h21;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   logic [31:0] line_words [32];
   logic [31:0] exp_mem [128];

   spu_dual_issue_front_if bus ();

   spu_dual_issue_front dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] rr(input logic [10:0] op, input logic [6:0] rb,
                                      input logic [6:0] ra, input logic [6:0] rt);
      return {op, rb, ra, rt};
   endfunction

   function automatic logic [31:0] ri10(input logic [7:0] op, input logic [9:0] imm,
                                        input logic [6:0] ra, input logic [6:0] rt);
      return {op, imm, ra, rt};
   endfunction

   function automatic logic [31:0] ri16(input logic [8:0] op, input logic [15:0] imm,
                                        input logic [6:0] rt);
      return {op, imm, rt};
   endfunction

   function automatic logic [31:0] ri18(input logic [6:0] op, input logic [17:0] imm,
                                        input logic [6:0] rt);
      return {op, imm, rt};
   endfunction

   // Conflict-free filler: even index -> AH, odd index -> SHLQBY reading r102/r5x.
   function automatic logic [31:0] make_word(input int tag, input int i);
      if ((i % 2) == 0) begin
         return rr(OP_AH, 7'd100, 7'(40 + tag), 7'(i));
      end
      return rr(OP_SHLQBY, 7'd102, 7'(50 + tag), 7'(i));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_line();
      for (int i = 0; i < 32; i++) line_words[i] = 32'h0;
   endtask

   // Drive one write edge with line_words at addr and record it in exp_mem.
   task automatic load_line(input logic [6:0] addr);
      for (int i = 0; i < 32; i++) begin
         bus.inst_2_local[32*i +: 32] = line_words[i];
         exp_mem[(int'(addr) + i) % 128] = line_words[i];
      end
      bus.instuction_address = addr;
      bus.write = 1'b1;
      tick();
      bus.write = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.write = 1'b0;
      bus.instuction_address = '0;
      bus.inst_2_local = '0;
      repeat (2) tick();
      checks++; if (bus.pc !== 7'd0) begin errors++; $display("[TB] FAIL reset_pc: got %0d expected 0", bus.pc); end
      checks++; if (bus.even_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_even_valid: got %b expected 0", bus.even_valid); end
      checks++; if (bus.odd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_odd_valid: got %b expected 0", bus.odd_valid); end
      checks++; if (bus.even_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_even_inst: got %h expected 0", bus.even_inst); end
      checks++; if (bus.odd_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_odd_inst: got %h expected 0", bus.odd_inst); end
      reset = 1'b1;
   endtask

   task automatic test_pair_issue();
      logic [31:0] w0, w1;
      w0 = rr(OP_AH, 7'd1, 7'd2, 7'd3);
      w1 = rr(OP_SHLQBI, 7'd4, 7'd5, 7'd6);
      clear_line(); line_words[0] = w0; line_words[1] = w1;
      load_line(7'd0);
      checks++; if (bus.even_valid !== 1'b0 || bus.odd_valid !== 1'b0) begin errors++; $display("[TB] FAIL write_valids: got %b%b expected 00", bus.even_valid, bus.odd_valid); end
      checks++; if (bus.pc !== 7'd0) begin errors++; $display("[TB] FAIL write_pc: got %0d expected 0", bus.pc); end
      tick();
      checks++; if (bus.even_inst !== w0 || bus.even_valid !== 1'b1) begin errors++; $display("[TB] FAIL pair_even: got %h/%b expected %h/1", bus.even_inst, bus.even_valid, w0); end
      checks++; if (bus.odd_inst !== w1 || bus.odd_valid !== 1'b1) begin errors++; $display("[TB] FAIL pair_odd: got %h/%b expected %h/1", bus.odd_inst, bus.odd_valid, w1); end
      checks++; if (bus.pc !== 7'd2) begin errors++; $display("[TB] FAIL pair_pc: got %0d expected 2", bus.pc); end
   endtask

   // Two words expected to split: first goes alone on pipe_a, second on pipe_b.
   task automatic run_split(input string name, input logic [31:0] w0, input logic [31:0] w1,
                            input logic a_odd, input logic b_odd);
      clear_line(); line_words[0] = w0; line_words[1] = w1;
      load_line(7'd0);
      tick();
      checks++;
      if ((a_odd ? bus.odd_inst : bus.even_inst) !== w0 || bus.even_valid !== !a_odd || bus.odd_valid !== a_odd || bus.pc !== 7'd0) begin
         errors++; $display("[TB] FAIL %s_first: got e=%h/%b o=%h/%b pc=%0d expected %h alone pc=0", name, bus.even_inst, bus.even_valid, bus.odd_inst, bus.odd_valid, bus.pc, w0);
      end
      checks++;
      if ((a_odd ? bus.even_inst : bus.odd_inst) !== 32'h0) begin
         errors++; $display("[TB] FAIL %s_idle_inst: got e=%h o=%h expected idle pipe 0", name, bus.even_inst, bus.odd_inst);
      end
      tick();
      checks++;
      if ((b_odd ? bus.odd_inst : bus.even_inst) !== w1 || bus.even_valid !== !b_odd || bus.odd_valid !== b_odd || bus.pc !== 7'd2) begin
         errors++; $display("[TB] FAIL %s_second: got e=%h/%b o=%h/%b pc=%0d expected %h alone pc=2", name, bus.even_inst, bus.even_valid, bus.odd_inst, bus.odd_valid, bus.pc, w1);
      end
   endtask

   task automatic test_split_hazards();
      run_split("odd_odd", rr(OP_GBB, 7'd0, 7'd7, 7'd8), rr(OP_ROTQBY, 7'd9, 7'd10, 7'd11), 1'b1, 1'b1);
      run_split("raw", ri10(OP_XORHI, 10'd5, 7'd12, 7'd13), rr(OP_ROTQBI, 7'd14, 7'd13, 7'd15), 1'b0, 1'b1);
      run_split("waw", ri18(OP_ILA, 18'h123, 7'd20), ri16(OP_LQA, 16'h40, 7'd20), 1'b0, 1'b1);
   endtask

   task automatic test_odd_first();
      logic [31:0] w0, w1;
      w0 = rr(OP_ROTQMBY, 7'd1, 7'd2, 7'd22);
      w1 = ri10(OP_CEQBI, 10'd7, 7'd23, 7'd24);
      clear_line(); line_words[0] = w0; line_words[1] = w1;
      load_line(7'd0);
      tick();
      checks++; if (bus.odd_inst !== w0 || bus.even_inst !== w1 || !bus.odd_valid || !bus.even_valid || bus.pc !== 7'd2) begin
         errors++; $display("[TB] FAIL odd_first: got e=%h/%b o=%h/%b pc=%0d expected e=%h o=%h pc=2", bus.even_inst, bus.even_valid, bus.odd_inst, bus.odd_valid, bus.pc, w1, w0);
      end
   endtask

   task automatic test_wrap_run();
      int exp_pc;
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 32; i++) line_words[i] = make_word(t, i);
         load_line(7'(32 * t));
      end
      for (int i = 0; i < 32; i++) line_words[i] = make_word(4, i);
      load_line(7'd120);
      for (int p = 0; p < 64; p++) begin
         tick();
         exp_pc = (2 * p + 2) % 128;
         checks++;
         if (bus.even_inst !== exp_mem[2*p] || bus.odd_inst !== exp_mem[2*p+1] || !bus.even_valid || !bus.odd_valid) begin
            errors++; $display("[TB] FAIL run_pair%0d: got e=%h o=%h v=%b%b expected e=%h o=%h v=11", p, bus.even_inst, bus.odd_inst, bus.even_valid, bus.odd_valid, exp_mem[2*p], exp_mem[2*p+1]);
         end
         checks++;
         if (bus.pc !== 7'(exp_pc)) begin
            errors++; $display("[TB] FAIL run_pc%0d: got %0d expected %0d", p, bus.pc, exp_pc);
         end
      end
   endtask

   task automatic test_write_mid_split();
      logic [31:0] w0, w1;
      w0 = rr(OP_AH, 7'd1, 7'd2, 7'd3);
      w1 = rr(OP_SFH, 7'd4, 7'd5, 7'd6);
      clear_line(); line_words[0] = w0; line_words[1] = w1;
      load_line(7'd0);
      tick();
      checks++; if (bus.even_inst !== w0 || !bus.even_valid || bus.odd_valid) begin errors++; $display("[TB] FAIL wsplit_first: got %h/%b/%b expected %h/1/0", bus.even_inst, bus.even_valid, bus.odd_valid, w0); end
      load_line(7'd0);
      checks++; if (bus.even_valid !== 1'b0 || bus.odd_valid !== 1'b0 || bus.pc !== 7'd0) begin errors++; $display("[TB] FAIL wsplit_flush: got v=%b%b pc=%0d expected v=00 pc=0", bus.even_valid, bus.odd_valid, bus.pc); end
      tick();
      checks++; if (bus.even_inst !== w0 || !bus.even_valid || bus.odd_valid || bus.pc !== 7'd0) begin errors++; $display("[TB] FAIL wsplit_restart: got %h/%b/%b pc=%0d expected %h/1/0 pc=0", bus.even_inst, bus.even_valid, bus.odd_valid, bus.pc, w0); end
      tick();
      checks++; if (bus.even_inst !== w1 || !bus.even_valid || bus.odd_valid || bus.pc !== 7'd2) begin errors++; $display("[TB] FAIL wsplit_second: got %h/%b/%b pc=%0d expected %h/1/0 pc=2", bus.even_inst, bus.even_valid, bus.odd_valid, bus.pc, w1); end
   endtask

   task automatic test_reset_mid_split();
      logic [31:0] w0, w1;
      w0 = rr(OP_AH, 7'd1, 7'd2, 7'd3);
      w1 = rr(OP_SFH, 7'd4, 7'd5, 7'd6);
      clear_line(); line_words[0] = w0; line_words[1] = w1;
      load_line(7'd0);
      tick();
      reset = 1'b0;
      #2;
      checks++; if (bus.even_valid !== 1'b0 || bus.odd_valid !== 1'b0 || bus.pc !== 7'd0 || bus.even_inst !== 32'h0) begin
         errors++; $display("[TB] FAIL rsplit_async: got v=%b%b pc=%0d e=%h expected v=00 pc=0 e=0", bus.even_valid, bus.odd_valid, bus.pc, bus.even_inst);
      end
      tick();
      reset = 1'b1;
      tick();
      checks++; if (bus.even_inst !== w0 || !bus.even_valid || bus.odd_valid || bus.pc !== 7'd0) begin errors++; $display("[TB] FAIL rsplit_restart: got %h/%b/%b pc=%0d expected %h/1/0 pc=0", bus.even_inst, bus.even_valid, bus.odd_valid, bus.pc, w0); end
      tick();
      checks++; if (bus.even_inst !== w1 || !bus.even_valid || bus.pc !== 7'd2) begin errors++; $display("[TB] FAIL rsplit_second: got %h/%b pc=%0d expected %h/1 pc=2", bus.even_inst, bus.even_valid, bus.pc, w1); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_pair_issue();
      test_split_hazards();
      test_odd_first();
      test_wrap_run();
      test_write_mid_split();
      test_reset_mid_split();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
